// File: rtl/portal_teleport_logic_if.sv
// portal_teleport_logic_if: frame tick, ball/portal coordinates in; teleport request handshake out.
interface portal_teleport_logic_if;
    logic               startOfFrame;
    logic signed [10:0] ballX;
    logic signed [10:0] ballY;
    logic signed [10:0] topLeftXBlue;
    logic signed [10:0] topLeftYBlue;
    logic signed [10:0] topLeftXOrange;
    logic signed [10:0] topLeftYOrange;
    logic               teleportAck;
    logic               teleportReq;
    logic signed [10:0] newX;
    logic signed [10:0] newY;
    logic               fromOrange;
    logic               busy;
    modport master (
        output startOfFrame, ballX, ballY, topLeftXBlue, topLeftYBlue,
               topLeftXOrange, topLeftYOrange, teleportAck,
        input  teleportReq, newX, newY, fromOrange, busy
    );
    modport slave (
        input  startOfFrame, ballX, ballY, topLeftXBlue, topLeftYBlue,
               topLeftXOrange, topLeftYOrange, teleportAck,
        output teleportReq, newX, newY, fromOrange, busy
    );
endinterface

// File: rtl/portal_teleport_logic.sv
// portal_teleport_logic: detects the ball centre inside a portal and requests a move to the other one.
module portal_teleport_logic #(
    parameter int PORTAL_SIZE     = 32,
    parameter int BALL_SIZE       = 16,
    parameter int COOLDOWN_FRAMES = 30
) (
    input logic                    clk,
    input logic                    reset,
    portal_teleport_logic_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, REQUEST, COOLDOWN} state_t;
    localparam int                 CW   = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic signed [11:0] HB   = 12'(BALL_SIZE / 2);
    localparam logic signed [11:0] PS   = 12'(PORTAL_SIZE);
    localparam logic signed [10:0] OFF  = 11'((PORTAL_SIZE - BALL_SIZE) / 2);
    localparam logic [CW-1:0]      LOAD = CW'(COOLDOWN_FRAMES);
    state_t             state_q, state_d;
    logic signed [10:0] bx_q, bx_d, by_q, by_d;
    logic signed [10:0] blx_q, blx_d, bly_q, bly_d;
    logic signed [10:0] orx_q, orx_d, ory_q, ory_d;
    logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
    logic               fo_q, fo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               in_blue, in_orange, live_in_any;
    // Centre and portal extents use 12 bits so 11-bit coordinates plus sizes never wrap.
    function automatic logic in_portal(input logic signed [10:0] x, y, px, py);
        logic signed [11:0] cx, cy, x0, y0;
        cx = $signed({x[10], x}) + HB;
        cy = $signed({y[10], y}) + HB;
        x0 = $signed({px[10], px});
        y0 = $signed({py[10], py});
        return (x0 <= cx) && (cx < x0 + PS) && (y0 <= cy) && (cy < y0 + PS);
    endfunction
    assign in_blue     = in_portal(bx_q, by_q, blx_q, bly_q);
    assign in_orange   = in_portal(bx_q, by_q, orx_q, ory_q);
    assign live_in_any = in_portal(bus.ballX, bus.ballY, blx_q, bly_q) ||
                         in_portal(bus.ballX, bus.ballY, orx_q, ory_q);
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        blx_d   = blx_q;
        bly_d   = bly_q;
        orx_d   = orx_q;
        ory_d   = ory_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        fo_d    = fo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.startOfFrame) begin
                bx_d    = bus.ballX;
                by_d    = bus.ballY;
                blx_d   = bus.topLeftXBlue;
                bly_d   = bus.topLeftYBlue;
                orx_d   = bus.topLeftXOrange;
                ory_d   = bus.topLeftYOrange;
                state_d = CHECK;
            end
            CHECK: begin
                nx_d    = in_blue ? orx_q + OFF : blx_q + OFF;
                ny_d    = in_blue ? ory_q + OFF : bly_q + OFF;
                fo_d    = !in_blue;
                state_d = (in_blue || in_orange) ? REQUEST : IDLE;
                if (!(in_blue || in_orange)) begin
                    nx_d = nx_q;
                    ny_d = ny_q;
                    fo_d = fo_q;
                end
            end
            REQUEST: if (bus.teleportAck) begin
                cnt_d   = LOAD;
                state_d = COOLDOWN;
            end
            COOLDOWN: if (bus.startOfFrame) begin
                cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
                if (cnt_q == '0) begin
                    bx_d    = bus.ballX;
                    by_d    = bus.ballY;
                    state_d = live_in_any ? COOLDOWN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            blx_q   <= '0;
            bly_q   <= '0;
            orx_q   <= '0;
            ory_q   <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            fo_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            blx_q   <= blx_d;
            bly_q   <= bly_d;
            orx_q   <= orx_d;
            ory_q   <= ory_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            fo_q    <= fo_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.teleportReq = state_q == REQUEST;
    assign bus.busy        = state_q != IDLE;
    assign bus.newX        = nx_q;
    assign bus.newY        = ny_q;
    assign bus.fromOrange  = fo_q;
endmodule

// File: tb/tb_portal_teleport_logic.sv
// tb_portal_teleport_logic: directed frames with a scoreboard of expected teleport destinations.
module tb_portal_teleport_logic;
    localparam int PS = 32;
    localparam int BS = 16;
    localparam int CD = 30;
    typedef struct packed {
        logic signed [10:0] x;
        logic signed [10:0] y;
        logic               fo;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   bpx, bpy, opx, opy;
    exp_t sb[$];
    exp_t last_e;
    always #5 clk = ~clk;
    portal_teleport_logic_if bus();
    portal_teleport_logic #(.PORTAL_SIZE(PS), .BALL_SIZE(BS), .COOLDOWN_FRAMES(CD)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask
    task automatic set_portals(input int bx, by, ox, oy);
        bpx = bx; bpy = by; opx = ox; opy = oy;
        bus.topLeftXBlue   = 11'(bx);
        bus.topLeftYBlue   = 11'(by);
        bus.topLeftXOrange = 11'(ox);
        bus.topLeftYOrange = 11'(oy);
    endtask
    task automatic sof_pulse(input int bx, by);
        bus.ballX = 11'(bx);
        bus.ballY = 11'(by);
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
    endtask
    // Frame issued from IDLE; reference model pushes the expected destination if it should teleport.
    task automatic launch(input int bx, by);
        int cx, cy;
        bit ib, io;
        cx = bx + BS / 2;
        cy = by + BS / 2;
        ib = cx >= bpx && cx < bpx + PS && cy >= bpy && cy < bpy + PS;
        io = cx >= opx && cx < opx + PS && cy >= opy && cy < opy + PS;
        if (ib) sb.push_back('{x: 11'(opx + (PS - BS) / 2), y: 11'(opy + (PS - BS) / 2), fo: 1'b0});
        else if (io) sb.push_back('{x: 11'(bpx + (PS - BS) / 2), y: 11'(bpy + (PS - BS) / 2), fo: 1'b1});
        sof_pulse(bx, by);
    endtask
    task automatic expect_req(input string tag);
        chk({tag, "_check_noreq"}, bus.teleportReq, 0);
        chk({tag, "_check_busy"}, bus.busy, 1);
        @(negedge clk);
        chk({tag, "_req"}, bus.teleportReq, 1);
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            last_e = sb.pop_front();
            chk({tag, "_newX"}, bus.newX, last_e.x);
            chk({tag, "_newY"}, bus.newY, last_e.y);
            chk({tag, "_fromOrange"}, bus.fromOrange, last_e.fo);
        end
    endtask
    task automatic expect_none(input string tag);
        chk({tag, "_check_busy"}, bus.busy, 1);
        chk({tag, "_check_noreq"}, bus.teleportReq, 0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, bus.busy, 0);
        chk({tag, "_idle_noreq"}, bus.teleportReq, 0);
    endtask
    task automatic hold_ack(input string tag);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_hold_req"}, bus.teleportReq, 1);
            chk({tag, "_hold_newX"}, bus.newX, last_e.x);
            chk({tag, "_hold_newY"}, bus.newY, last_e.y);
        end
        bus.teleportAck = 1'b1;
        @(negedge clk);
        bus.teleportAck = 1'b0;
        chk({tag, "_ack_drop"}, bus.teleportReq, 0);
        chk({tag, "_ack_busy"}, bus.busy, 1);
    endtask
    task automatic cd_frames(input string tag, input int n, bx, by, input logic last_busy);
        for (int i = 0; i < n; i++) begin
            sof_pulse(bx, by);
            chk({tag, "_cd_noreq"}, bus.teleportReq, 0);
            chk({tag, "_cd_busy"}, bus.busy, i == n - 1 ? last_busy : 1'b1);
        end
    endtask
    initial begin
        bus.startOfFrame = 1'b0;
        bus.teleportAck  = 1'b0;
        bus.ballX = '0;
        bus.ballY = '0;
        set_portals(220, 110, 440, 338);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", bus.teleportReq, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_newX", bus.newX, 0);
        chk("rst_newY", bus.newY, 0);
        chk("rst_fromOrange", bus.fromOrange, 0);
        reset = 1'b0;
        @(negedge clk);
        launch(228, 118);
        expect_req("blue_entry");
        hold_ack("blue_entry");
        cd_frames("stay_orange", CD + 2, 448, 346, 1'b1);
        cd_frames("leave", 1, 300, 300, 1'b0);
        launch(448, 346);
        expect_req("orange_entry");
        hold_ack("orange_entry");
        cd_frames("cd_len", CD + 1, 100, 100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            launch(100, 100);
            expect_none("miss");
        end
        launch(244, 118);
        expect_none("edge_out");
        launch(243, 118);
        expect_req("edge_in");
        hold_ack("edge_in");
        cd_frames("edge_cd", CD + 1, 100, 100, 1'b0);
        launch(228, 118);
        expect_req("pre_reset");
        #2 reset = 1'b1;
        #1;
        chk("async_req", bus.teleportReq, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_newX", bus.newX, 0);
        chk("async_newY", bus.newY, 0);
        chk("async_fromOrange", bus.fromOrange, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_req", bus.teleportReq, 0);
            chk("post_reset_busy", bus.busy, 0);
        end
        launch(100, 100);
        expect_none("post_reset_miss");
        launch(228, 118);
        expect_req("post_reset_hit");
        hold_ack("post_reset_hit");
        #2 reset = 1'b1;
        #1 chk("cd_reset_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(228, 200);
        expect_none("cd_reset_resume");
        set_portals(500, 500, 500, 500);
        launch(508, 508);
        expect_req("priority");
        hold_ack("priority");
        cd_frames("priority_cd", CD + 1, 100, 100, 1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
